// File: rtl/lfsr_period_monitor.sv
// -----------------------------------------------------------------------------
// lfsr_period_monitor
//
// Watches an LFSR stage one step at a time. The first step after arming
// captures a reference state; the monitor then counts steps until the
// reference reappears and confirms that the sequence period equals
// EXPECTED_PERIOD and that max_tick fired exactly once in that period.
// Lock-up (all-zero), stuck states, short periods, overrunning periods and
// wrong tick counts are reported through fault_code.
//
// Build option:
//   LFSR_MON_CONTINUOUS_EN - when defined, a passing period does not stop the
//   monitor: pass pulses for one cycle, pass_count increments (saturating)
//   and measurement restarts with the closing value as the new reference.
//   When undefined, PASS is terminal until start and pass_count reads 0.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   start       one-cycle re-arm pulse, highest priority
//   step_en     qualifies lfsr_value / max_tick for this cycle
//   lfsr_value  current LFSR state
//   max_tick    LFSR wrap flag
//   busy        high while arming or counting
//   pass        period verified
//   fail        a check failed; reason in fault_code
//   fault_code  0 none, 1 ZERO, 2 STUCK, 3 SHORT, 4 TIMEOUT, 5 TICK
//   period      last measured period, saturating
//   pass_count  completed passing periods (continuous build only)
// -----------------------------------------------------------------------------
module lfsr_period_monitor #(
  parameter int WIDTH           = 22,
  parameter int EXPECTED_PERIOD = 4194303
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step_en,
  input  logic [WIDTH-1:0] lfsr_value,
  input  logic             max_tick,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [2:0]       fault_code,
  output logic [WIDTH-1:0] period,
  output logic [7:0]       pass_count
);

  localparam logic [1:0] ST_ARM   = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_PASS  = 2'd2;
  localparam logic [1:0] ST_FAIL  = 2'd3;

  localparam logic [2:0] CODE_NONE    = 3'd0;
  localparam logic [2:0] CODE_ZERO    = 3'd1;
  localparam logic [2:0] CODE_STUCK   = 3'd2;
  localparam logic [2:0] CODE_SHORT   = 3'd3;
  localparam logic [2:0] CODE_TIMEOUT = 3'd4;
  localparam logic [2:0] CODE_TICK    = 3'd5;

  // One extra bit so the step count can reach EXPECTED_PERIOD without wrapping.
  localparam logic [WIDTH:0] EXP_STEPS = (WIDTH+1)'(EXPECTED_PERIOD);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH:0]   steps_q, steps_d;
  logic [1:0]       ticks_q, ticks_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [2:0]       code_q, code_d;
  logic [WIDTH-1:0] period_q, period_d;
`ifdef LFSR_MON_CONTINUOUS_EN
  logic [7:0]       pass_count_q, pass_count_d;
`endif

  logic [WIDTH:0] steps_inc;
  logic [1:0]     ticks_inc;

  // Anything above the WIDTH-bit display range shows as all ones.
  function automatic logic [WIDTH-1:0] sat_period(input logic [WIDTH:0] n);
    return n[WIDTH] ? '1 : n[WIDTH-1:0];
  endfunction

  assign steps_inc = steps_q + 1'b1;
  assign ticks_inc = (max_tick && ticks_q != 2'd3) ? ticks_q + 2'd1 : ticks_q;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d  = state_q;
    ref_d    = ref_q;
    prev_d   = prev_q;
    steps_d  = steps_q;
    ticks_d  = ticks_q;
`ifdef LFSR_MON_CONTINUOUS_EN
    pass_d       = 1'b0;  // pass is a one-cycle pulse in continuous mode
    pass_count_d = pass_count_q;
`else
    pass_d   = pass_q;
`endif
    fail_d   = fail_q;
    code_d   = code_q;
    period_d = period_q;

    if (start) begin
      state_d = ST_ARM;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      code_d  = CODE_NONE;
      ref_d   = '0;
      prev_d  = '0;
      steps_d = '0;
      ticks_d = '0;
    end else if (step_en) begin
      case (state_q)
        ST_ARM: begin
          // Tick on the capture step belongs to the previous period.
          ref_d   = lfsr_value;
          prev_d  = lfsr_value;
          steps_d = '0;
          ticks_d = '0;
          state_d = ST_COUNT;
        end
        ST_COUNT: begin
          steps_d = steps_inc;
          ticks_d = ticks_inc;
          prev_d  = lfsr_value;
          if (lfsr_value == '0) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
            code_d  = CODE_ZERO;
          end else if (lfsr_value == prev_q) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
            code_d  = CODE_STUCK;
          end else if (lfsr_value == ref_q) begin
            period_d = sat_period(steps_inc);
            if (steps_inc < EXP_STEPS) begin
              state_d = ST_FAIL;
              fail_d  = 1'b1;
              code_d  = CODE_SHORT;
            end else if (ticks_inc == 2'd1) begin
`ifdef LFSR_MON_CONTINUOUS_EN
              pass_d       = 1'b1;
              pass_count_d = (pass_count_q == 8'hff) ? pass_count_q : pass_count_q + 8'd1;
              state_d      = ST_COUNT;
              ref_d        = lfsr_value;
              steps_d      = '0;
              ticks_d      = '0;
`else
              state_d = ST_PASS;
              pass_d  = 1'b1;
`endif
            end else begin
              state_d = ST_FAIL;
              fail_d  = 1'b1;
              code_d  = CODE_TICK;
            end
          end else if (steps_inc == EXP_STEPS) begin
            state_d  = ST_FAIL;
            fail_d   = 1'b1;
            code_d   = CODE_TIMEOUT;
            period_d = sat_period(EXP_STEPS);
          end
        end
        default: ;  // PASS and FAIL ignore steps until start
      endcase
    end
  end

  // NOTE: all state here is a handful of flops, so every register is reset;
  // sequential updates use non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_ARM;
      ref_q        <= '0;
      prev_q       <= '0;
      steps_q      <= '0;
      ticks_q      <= '0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      code_q       <= CODE_NONE;
      period_q     <= '0;
`ifdef LFSR_MON_CONTINUOUS_EN
      pass_count_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ref_q        <= ref_d;
      prev_q       <= prev_d;
      steps_q      <= steps_d;
      ticks_q      <= ticks_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      code_q       <= code_d;
      period_q     <= period_d;
`ifdef LFSR_MON_CONTINUOUS_EN
      pass_count_q <= pass_count_d;
`endif
    end
  end

  assign busy       = (state_q == ST_ARM) || (state_q == ST_COUNT);
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign fault_code = code_q;
  assign period     = period_q;
`ifdef LFSR_MON_CONTINUOUS_EN
  assign pass_count = pass_count_q;
`else
  assign pass_count = 8'd0;
`endif

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// -----------------------------------------------------------------------------
// tb_lfsr_period_monitor
//
// Drives lfsr_period_monitor (WIDTH=4, EXPECTED_PERIOD=15) from a software
// LFSR x^4+x^3+1 seeded 4'b0001, with corrupted variants for each fault
// class, and compares every output on every cycle against a reference model
// that keeps the captured sequence in a queue. Build option
// LFSR_MON_CONTINUOUS_EN selects the continuous-mode directed scenario.
// -----------------------------------------------------------------------------
module tb_lfsr_period_monitor;

  localparam int W  = 4;
  localparam int EP = 15;

`ifdef LFSR_MON_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  localparam int K_GOOD    = 0;
  localparam int K_ZERO    = 1;
  localparam int K_STUCK   = 2;
  localparam int K_SHORT   = 3;
  localparam int K_NOTICK  = 4;
  localparam int K_TIMEOUT = 5;
  localparam int K_RAND    = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         step_en = 1'b0;
  logic [W-1:0] lfsr_value = '0;
  logic         max_tick = 1'b0;
  logic         busy, pass, fail;
  logic [2:0]   fault_code;
  logic [W-1:0] period;
  logic [7:0]   pass_count;

  always #5 clk = ~clk;

  lfsr_period_monitor #(.WIDTH(W), .EXPECTED_PERIOD(EP)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .step_en    (step_en),
    .lfsr_value (lfsr_value),
    .max_tick   (max_tick),
    .busy       (busy),
    .pass       (pass),
    .fail       (fail),
    .fault_code (fault_code),
    .period     (period),
    .pass_count (pass_count)
  );

  int checks = 0;
  int failures = 0;
  int pass_pulses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_busy, m_pass, m_fail;
  int m_code, m_period, m_pass_count, m_ticks;
  int hist[$];  // values seen since capture; hist[0] is the reference

  function automatic void model_reset();
    m_busy = 1'b1; m_pass = 1'b0; m_fail = 1'b0;
    m_code = 0; m_period = 0; m_pass_count = 0; m_ticks = 0;
    hist.delete();
  endfunction

  function automatic void model_fail(input int code);
    m_busy = 1'b0; m_fail = 1'b1; m_code = code;
  endfunction

  function automatic void model_step(input bit st, input bit se, input int v, input bit tk);
    int k;
    if (CONT) m_pass = 1'b0;
    if (st) begin
      m_busy = 1'b1; m_pass = 1'b0; m_fail = 1'b0; m_code = 0;
      m_ticks = 0; hist.delete();
      return;
    end
    if (!se || !m_busy) return;
    if (hist.size() == 0) begin
      hist.push_back(v);
      m_ticks = 0;
      return;
    end
    k = hist.size();  // steps counted including this one
    m_ticks += int'(tk);
    if (v == 0) model_fail(1);
    else if (v == hist[$]) model_fail(2);
    else if (v == hist[0]) begin
      m_period = k;
      if (k < EP) model_fail(3);
      else if (m_ticks != 1) model_fail(5);
      else if (CONT) begin
        m_pass = 1'b1;
        if (m_pass_count < 255) m_pass_count++;
        hist.delete(); hist.push_back(v); m_ticks = 0;
      end else begin
        m_busy = 1'b0; m_pass = 1'b1;
      end
    end else if (k == EP) begin
      m_period = EP;
      model_fail(4);
    end else hist.push_back(v);
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic int lfsr_at(input int n);
    int s = 1;
    for (int i = 0; i < (n % 15); i++) s = ((s << 1) & 15) | (((s >> 3) ^ (s >> 2)) & 1);
    return s;
  endfunction

  function automatic int stim_val(input int kind, input int i, input int off);
    case (kind)
      K_ZERO:    return (i == 4) ? 0 : lfsr_at(i);
      K_STUCK:   return (i <= 3) ? lfsr_at(i) : lfsr_at(i - 1);  // 1001 twice
      K_SHORT:   return lfsr_at(i % 7);
      K_TIMEOUT: return (i == 0) ? 1 : ((i % 2) ? 2 : 3);
      K_RAND:    return int'($urandom_range(0, 15));
      default:   return lfsr_at(i + off);
    endcase
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".busy"},  busy,       m_busy);
    check({tag, ".pass"},  pass,       m_pass);
    check({tag, ".fail"},  fail,       m_fail);
    check({tag, ".code"},  fault_code, m_code);
    check({tag, ".period"}, period,    m_period);
    check({tag, ".count"}, pass_count, m_pass_count);
  endtask

  // Drive at a falling edge, let the rising edge act, compare at the next fall.
  task automatic cycle(input bit st, input bit se, input int v, input bit tk);
    start = st; step_en = se; lfsr_value = W'(v); max_tick = tk;
    @(posedge clk);
    model_step(st, se, v, tk);
    @(negedge clk);
    start = 1'b0; step_en = 1'b0;
    if (pass === 1'b1) pass_pulses++;
    compare_all("cyc");
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
  endtask

  task automatic do_start();
    cycle(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
  endtask

  // gap < 0 selects a random 0..3 idle cycles between steps.
  task automatic run_seq(input int kind, input int off, input int max_steps,
                         input int gap, input bit rand_start);
    int v;
    bit tk;
    for (int i = 0; i < max_steps; i++) begin
      v  = stim_val(kind, i, off);
      tk = (kind == K_NOTICK) ? 1'b0 : (v == 1);
      if (rand_start && $urandom_range(0, 24) == 0) do_start();
      cycle(1'b0, 1'b1, v, tk);
      if (!m_busy) break;
      idle((gap < 0) ? int'($urandom_range(0, 3)) : gap);
    end
  endtask

  task automatic async_reset_check();
    #2 reset = 1'b0;
    #1 model_reset();
    compare_all("async");
    check("async.busy_hi", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    compare_all("async_rel");
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all("rst");
    check("rst.busy_hi", busy, 1);
    check("rst.period0", period, 0);
    reset = 1'b1;
    idle(2);

`ifndef LFSR_MON_CONTINUOUS_EN
    run_seq(K_GOOD, 0, 16, 2, 1'b0);
    check("good.pass", pass, 1);
    check("good.code", fault_code, 0);
    check("good.period", period, 15);
    check("good.busy", busy, 0);
    run_seq(K_RAND, 0, 3, 0, 1'b0);  // steps ignored while holding
    check("good.hold", pass, 1);
    do_start();

    run_seq(K_ZERO, 0, 20, 2, 1'b0);
    check("zero.fail", fail, 1);
    check("zero.code", fault_code, 1);
    check("zero.pass", pass, 0);
    do_start();

    run_seq(K_STUCK, 0, 20, 2, 1'b0);
    check("stuck.code", fault_code, 2);
    do_start();

    run_seq(K_SHORT, 0, 20, 1, 1'b0);
    check("short.code", fault_code, 3);
    check("short.period", period, 7);
    do_start();
    run_seq(K_GOOD, 0, 16, 2, 1'b0);
    check("rearm.pass", pass, 1);
    check("rearm.period", period, 15);
    do_start();

    run_seq(K_NOTICK, 0, 20, 0, 1'b0);
    check("tick.code", fault_code, 5);
    check("tick.period", period, 15);
    do_start();

    run_seq(K_TIMEOUT, 0, 20, 0, 1'b0);
    check("tmo.code", fault_code, 4);
    check("tmo.period", period, 15);
    do_start();

    run_seq(K_GOOD, 0, 8, 2, 1'b0);
    async_reset_check();
    run_seq(K_GOOD, 0, 16, -1, 1'b0);
    check("postrst.pass", pass, 1);
`else
    pass_pulses = 0;
    run_seq(K_GOOD, 0, 46, -1, 1'b0);
    idle(2);
    check("cont.pulses", pass_pulses, 3);
    check("cont.count", pass_count, 3);
    check("cont.busy", busy, 1);
    check("cont.fail", fail, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      do_start();
      run_seq(int'($urandom_range(0, 6)), int'($urandom_range(0, 14)), 20, -1, 1'b1);
      idle(int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_period_monitor.md
Name: lfsr_period_monitor

Overview:
- Downstream consumer of the LFSR stage. Samples the LFSR value and its max_tick flag on each LFSR step.
- Measures the sequence period from a captured reference state and checks it against the expected maximal length.
- Detects lock-up and stuck states, and checks that max_tick fires exactly once per period.
- Drives pass/fail status LEDs and exposes the measured period for display.

Parameters:
- WIDTH, 22, LFSR register width.
- EXPECTED_PERIOD, 4194303, required period in steps (2^WIDTH-1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; re-arms the monitor from any state.
- step_en  input  1  one-cycle pulse; lfsr_value/max_tick valid this cycle.
- lfsr_value  input  WIDTH  current LFSR state.
- max_tick  input  1  LFSR wrap flag, sampled only when step_en=1.
- busy  output  1  high in ARM or COUNT.
- pass  output  1  period verified.
- fail  output  1  check failed.
- fault_code  output  3  0 none, 1 ZERO, 2 STUCK, 3 SHORT, 4 TIMEOUT, 5 TICK.
- period  output  WIDTH  last measured period, saturating.
- pass_count  output  8  completed passing periods (see optional feature).

Behaviour:
- Reset (reset=0, asynchronous): state=ARM, busy=1, pass=0, fail=0, fault_code=0, period=0, pass_count=0, internal counters=0.
- States: ARM, COUNT, PASS, FAIL. Only cycles with step_en=1 advance ARM/COUNT.
- ARM, on step: ref<=value, prev<=value, steps<=0, ticks<=0 → COUNT. max_tick on the capture step is not counted.
- COUNT, on step:
  - steps<=steps+1; ticks<=ticks+max_tick (2-bit saturating); prev<=value.
  - Checks are evaluated on the same step, in priority order:
    - value==0 → FAIL, code 1 (ZERO).
    - value==prev → FAIL, code 2 (STUCK).
    - value==ref and steps+1 < EXPECTED_PERIOD → FAIL, code 3 (SHORT).
    - value==ref and steps+1 == EXPECTED_PERIOD:
      - ticks incl. this step ==1 → PASS.
      - otherwise → FAIL, code 5 (TICK).
    - steps+1 == EXPECTED_PERIOD and value!=ref → FAIL, code 4 (TIMEOUT).
  - period<=steps+1 on any SHORT/PASS/TICK exit. On TIMEOUT, period<=EXPECTED_PERIOD.
- Latency: pass/fail/fault_code/period are registered and valid on the edge following the deciding step_en cycle.
- PASS/FAIL: busy=0; outputs hold until start or reset; step_en is ignored.
- start=1: highest priority in any state. Next state=ARM, pass=fail=0, fault_code=0, counters cleared. period and pass_count are held. A coincident step_en is ignored; capture happens on the next step_en.
- Step counter is WIDTH+1 bits, so no wrap occurs before the TIMEOUT compare.
- Reset asserted mid-COUNT: immediate return to reset values; no partial verdict is retained.

Optional Feature:
- Macro: LFSR_MON_CONTINUOUS_EN.
- Defined:
  - On a PASS decision, pass is pulsed for one cycle, pass_count increments (saturating at 255), and the state goes directly to COUNT.
  - The closing value becomes the new ref; steps and ticks restart at 0 on that same step.
  - A FAIL decision stops in FAIL as normal.
- Undefined: PASS is terminal until start; pass_count is tied to 0.

Test Plan:
- WIDTH=4, EXPECTED_PERIOD=15, model LFSR x^4+x^3+1 seeded 4'b0001, max_tick when value==seed. Stepping once every 3 clk → pass=1, fault_code=0, period=15 one clk after the 16th step_en; busy=0.
- Same setup, model forced to 4'b0000 at step 5 → fail=1, fault_code=1, pass=0.
- Same setup, model repeats value 4'b1001 on two consecutive steps → fail=1, fault_code=2.
- Model truncated to a period of 7 → fail=1, fault_code=3, period=7. Then pulse start and restore the good model → pass=1, period=15.
- Model with max_tick suppressed → fail=1, fault_code=5 after 15 counted steps. Separately, drive reset low at step 8 → all outputs at reset values asynchronously; after release, a full run yields pass=1.
- LFSR_MON_CONTINUOUS_EN defined, good model, 3 full periods → pass pulses 3 times, pass_count=3, busy stays 1, fail=0.
